// File: rtl/mdu_seq.sv
// Multiply/divide sequencer for the EX stage. Owns HI/LO, models a fixed
// multi-cycle latency with a down-counter and reports busy/start_pending
// to the stall unit.
module mdu_seq #(
  parameter int unsigned MUL_CYCLES = 5,
  parameter int unsigned DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        start_pending,
  output logic        dz_err
);

  localparam logic [2:0] OpMult  = 3'd1;
  localparam logic [2:0] OpMultu = 3'd2;
  localparam logic [2:0] OpDiv   = 3'd3;
  localparam logic [2:0] OpDivu  = 3'd4;
  localparam logic [2:0] OpMthi  = 3'd5;
  localparam logic [2:0] OpMtlo  = 3'd6;

  localparam logic [3:0] MulCount = 4'(MUL_CYCLES);
  localparam logic [3:0] DivCount = 4'(DIV_CYCLES);

  typedef enum logic {StIdle, StRun} mduState_e;

  mduState_e   stateQ;
  logic [3:0]  countQ;
  logic [63:0] pendingQ;
  logic        writeBackQ;

  logic        isMulDiv;
  logic        isDiv;
  logic        divSigned;
  logic        divByZero;
  logic [63:0] mulA;
  logic [63:0] mulB;
  logic [63:0] product;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [31:0] safeDivisor;
  logic [31:0] quoMag;
  logic [31:0] remMag;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic [63:0] result;

  // Command decode and stall request; busy is registered so this has no loop.
  always_comb begin
    isMulDiv      = (op == OpMult) || (op == OpMultu) || (op == OpDiv) || (op == OpDivu);
    isDiv         = (op == OpDiv) || (op == OpDivu);
    divSigned     = (op == OpDiv);
    divByZero     = isDiv && (b == 32'd0);
    start_pending = isMulDiv && !flush && !busy;
  end

  // 64-bit result from the operands; signed divide works on magnitudes so the
  // 0x80000000 / -1 case falls out as 0x80000000 rem 0 without overflow.
  always_comb begin
    if (op == OpMult) begin
      mulA = {{32{a[31]}}, a};
      mulB = {{32{b[31]}}, b};
    end else begin
      mulA = {32'd0, a};
      mulB = {32'd0, b};
    end
    product     = mulA * mulB;
    dividend    = (divSigned && a[31]) ? (~a + 32'd1) : a;
    divisor     = (divSigned && b[31]) ? (~b + 32'd1) : b;
    // Zero divisor result is never written back; avoid a divide by zero here.
    safeDivisor = (divisor == 32'd0) ? 32'd1 : divisor;
    quoMag      = dividend / safeDivisor;
    remMag      = dividend % safeDivisor;
    quotient    = (divSigned && (a[31] ^ b[31])) ? (~quoMag + 32'd1) : quoMag;
    remainder   = (divSigned && a[31]) ? (~remMag + 32'd1) : remMag;
    result      = isDiv ? {remainder, quotient} : product;
  end

  // Sequencer FSM with registered HI/LO, busy and sticky divide-by-zero flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      stateQ     <= StIdle;
      countQ     <= 4'd0;
      pendingQ   <= 64'd0;
      writeBackQ <= 1'b0;
      hi         <= 32'd0;
      lo         <= 32'd0;
      busy       <= 1'b0;
      dz_err     <= 1'b0;
    end else begin
      unique case (stateQ)
        StIdle: begin
          if (!flush) begin
            if (isMulDiv) begin
              stateQ     <= StRun;
              busy       <= 1'b1;
              countQ     <= isDiv ? DivCount : MulCount;
              pendingQ   <= result;
              writeBackQ <= !divByZero;
              if (divByZero) begin
                dz_err <= 1'b1;
              end
            end else if (op == OpMthi) begin
              hi <= a;
            end else if (op == OpMtlo) begin
              lo <= a;
            end
          end
        end
        StRun: begin
          // Commands (and flush) are ignored while running.
          if (countQ == 4'd1) begin
            stateQ <= StIdle;
            busy   <= 1'b0;
            countQ <= 4'd0;
            if (writeBackQ) begin
              hi <= pendingQ[63:32];
              lo <= pendingQ[31:0];
            end
          end else begin
            countQ <= countQ - 4'd1;
          end
        end
        default: begin
          stateQ <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_seq.sv
// Self-checking bench for mdu_seq: table-driven arithmetic vectors plus
// directed sequences for flush, busy-time commands, divide by zero and reset.
module tb_mdu_seq;

  localparam int MulCyc = 5;
  localparam int DivCyc = 10;

  logic        clk;
  logic        reset;
  logic        flush;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        start_pending;
  logic        dz_err;

  int checks;
  int failures;

  mdu_seq #(
    .MUL_CYCLES(MulCyc),
    .DIV_CYCLES(DivCyc)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .op           (op),
    .a            (a),
    .b            (b),
    .hi           (hi),
    .lo           (lo),
    .busy         (busy),
    .start_pending(start_pending),
    .dz_err       (dz_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          cycles;
    logic [31:0] expHi;
    logic [31:0] expLo;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Count negedges with busy high; ends at the first negedge with busy low.
  task automatic waitBusy(output int n);
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
  endtask

  int n;

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    flush    = 1'b0;
    op       = 3'd5;  // MTHI during reset must lose
    a        = 32'h99;
    b        = 32'd0;

    vecs[0] = '{3'd1, 32'hFFFFFFFE, 32'h3,        MulCyc, 32'hFFFFFFFF, 32'hFFFFFFFA};
    vecs[1] = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, MulCyc, 32'hFFFFFFFE, 32'h00000001};
    vecs[2] = '{3'd3, 32'hFFFFFFF9, 32'h2,        DivCyc, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3] = '{3'd3, 32'h80000000, 32'hFFFFFFFF, DivCyc, 32'h00000000, 32'h80000000};
    vecs[4] = '{3'd4, 32'd100,      32'd7,        DivCyc, 32'd2,        32'd14};
    vecs[5] = '{3'd3, 32'd7,        32'hFFFFFFFE, DivCyc, 32'h00000001, 32'hFFFFFFFD};
    vecs[6] = '{3'd1, 32'h7FFFFFFF, 32'h7FFFFFFF, MulCyc, 32'h3FFFFFFF, 32'h00000001};
    vecs[7] = '{3'd4, 32'hFFFFFFFF, 32'h10,       DivCyc, 32'h0000000F, 32'h0FFFFFFF};

    repeat (2) @(negedge clk);
    reset = 1'b0;
    op    = 3'd0;
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_dz", {31'd0, dz_err}, 32'd0);

    // Arithmetic vectors
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      op = vecs[i].op;
      a  = vecs[i].a;
      b  = vecs[i].b;
      #1;
      check($sformatf("v%0d_start_pending", i), {31'd0, start_pending}, 32'd1);
      @(negedge clk);
      op = 3'd0;
      check($sformatf("v%0d_hi_held", i), hi, (i == 0) ? 32'd0 : vecs[i-1].expHi);
      waitBusy(n);
      check($sformatf("v%0d_cycles", i), n, vecs[i].cycles);
      check($sformatf("v%0d_hi", i), hi, vecs[i].expHi);
      check($sformatf("v%0d_lo", i), lo, vecs[i].expLo);
    end
    check("dz_clear", {31'd0, dz_err}, 32'd0);

    // MTHI / MTLO then divide by zero
    @(negedge clk);
    op = 3'd5;
    a  = 32'h11;
    #1;
    check("mthi_no_sp", {31'd0, start_pending}, 32'd0);
    @(negedge clk);
    op = 3'd6;
    a  = 32'h22;
    check("mthi_hi", hi, 32'h11);
    check("mthi_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    op = 3'd3;
    a  = 32'd50;
    b  = 32'd0;
    check("mtlo_lo", lo, 32'h22);
    @(negedge clk);
    op = 3'd0;
    check("dz_set_at_start", {31'd0, dz_err}, 32'd1);
    waitBusy(n);
    check("dz_cycles", n, DivCyc);
    check("dz_hi", hi, 32'h11);
    check("dz_lo", lo, 32'h22);

    // Flush blocks acceptance
    @(negedge clk);
    op    = 3'd1;
    a     = 32'd2;
    b     = 32'd3;
    flush = 1'b1;
    #1;
    check("flush_sp", {31'd0, start_pending}, 32'd0);
    @(negedge clk);
    flush = 1'b0;
    op    = 3'd0;
    check("flush_busy", {31'd0, busy}, 32'd0);
    check("flush_hi", hi, 32'h11);
    check("flush_lo", lo, 32'h22);

    // Flush during RUN does not cancel
    @(negedge clk);
    op = 3'd1;
    a  = 32'd2;
    b  = 32'd3;
    @(negedge clk);
    op = 3'd0;
    check("run_c1_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    waitBusy(n);
    check("flush_run_cycles", n, MulCyc - 2);
    check("flush_run_hi", hi, 32'd0);
    check("flush_run_lo", lo, 32'd6);
    check("dz_sticky", {31'd0, dz_err}, 32'd1);

    // MTLO held during RUN and across the completion edge is ignored
    @(negedge clk);
    op = 3'd1;
    a  = 32'd3;
    b  = 32'd4;
    @(negedge clk);
    op = 3'd6;
    a  = 32'h5555;
    #1;
    check("busy_no_sp", {31'd0, start_pending}, 32'd0);
    waitBusy(n);
    op = 3'd0;
    check("mtlo_busy_cycles", n, MulCyc);
    check("mtlo_busy_lo", lo, 32'd12);
    @(negedge clk);
    check("mtlo_busy_lo_after", lo, 32'd12);
    check("mtlo_busy_idle", {31'd0, busy}, 32'd0);

    @(negedge clk);
    op = 3'd5;
    a  = 32'hDEAD;
    @(negedge clk);
    op = 3'd0;
    check("mthi_dead", hi, 32'hDEAD);

    // Reset in busy cycle 3 discards the operation
    @(negedge clk);
    op = 3'd2;
    a  = 32'd5;
    b  = 32'd5;
    @(negedge clk);
    op = 3'd0;
    @(negedge clk);
    @(negedge clk);
    check("pre_reset_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midreset_busy", {31'd0, busy}, 32'd0);
    check("midreset_hi", hi, 32'd0);
    check("midreset_lo", lo, 32'd0);
    check("midreset_dz", {31'd0, dz_err}, 32'd0);
    repeat (8) @(negedge clk);
    check("midreset_lo_later", lo, 32'd0);
    check("midreset_busy_later", {31'd0, busy}, 32'd0);

    // Reply to reset-wins at start was checked above; op 7 does nothing
    @(negedge clk);
    op = 3'd7;
    a  = 32'h77;
    #1;
    check("op7_sp", {31'd0, start_pending}, 32'd0);
    @(negedge clk);
    op = 3'd0;
    check("op7_busy", {31'd0, busy}, 32'd0);
    check("op7_hi", hi, 32'd0);
    check("op7_lo", lo, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mdu_seq.md
Name: mdu_seq

Overview:
- Multiply/divide sequencer for the EX stage of the 5-stage pipeline. It owns the HI/LO registers.
- It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO commands and models fixed multi-cycle latency with a down-counter.
- It drives `busy` and `start_pending` for the stall unit, and honours the pipeline flush raised by CP0 interrupt/exception requests.

Parameters:
- MUL_CYCLES, 5, busy cycles for MULT/MULTU (legal range 1..15)
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (legal range 1..15)

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- flush  input  1  pipeline flush (IntReq); suppresses any command in the same cycle
- op  input  3  command: 0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as none)
- a  input  32  forwarded rs operand
- b  input  32  forwarded rt operand
- hi  output  32  HI register
- lo  output  32  LO register
- busy  output  1  operation in progress
- start_pending  output  1  combinational: (op in 1..4) & ~flush & ~busy; the stall unit ORs this with busy
- dz_err  output  1  sticky flag: divide by zero seen; cleared only by reset

Behaviour:
- Reset (synchronous, clk edge with reset=1): hi=0, lo=0, busy=0, counter=0, pending result=0, dz_err=0. Reset overrides every other input, including mid-operation; any in-flight result is discarded.
- States:
  - IDLE: counter==0, busy=0.
  - RUN: counter>0, busy=1.
- IDLE -> RUN: at an edge where op in {1..4}, flush=0 and busy=0.
  - counter loads MUL_CYCLES (op 1,2) or DIV_CYCLES (op 3,4).
  - The 64-bit result is computed from a/b at that edge and held in the pending register.
  - hi/lo are unchanged at this edge.
- RUN: counter decrements each edge. At the edge where counter==1: hi/lo <= pending, counter->0, busy->0.
  - busy is therefore high for exactly N cycles after the start edge.
  - New hi/lo are visible in the first cycle busy is low.
- Commands presented while busy=1 are ignored. This covers all ops, including MTHI/MTLO; the stall unit guarantees they do not occur.
- MTHI (5) / MTLO (6): with busy=0 and flush=0, hi<=a / lo<=a at the next edge. There is no busy phase.
- flush=1 blocks acceptance of any command in that cycle. An operation already in RUN is NOT cancelled by flush; its instruction has committed past EX, and it completes normally.
- Arithmetic:
  - MULT: signed 32x32 -> 64; hi=upper 32 bits, lo=lower 32 bits.
  - MULTU: same as MULT, unsigned.
  - DIV: signed. lo=quotient truncated toward zero; hi=remainder with the sign of the dividend.
  - DIV special case: a=0x80000000, b=0xFFFFFFFF gives lo=0x80000000, hi=0.
  - DIVU: unsigned. lo=quotient, hi=remainder.
  - Divide by zero (b==0, op 3/4): still runs DIV_CYCLES with busy high. hi/lo are left unchanged at completion, and dz_err is set at the start edge.
- Simultaneous events:
  - Completion edge with a new op asserted: the op is ignored, because busy is still 1 in that cycle.
  - reset and op in the same cycle: reset wins.
- op 0 and op 7 never change state.

Test Plan:
- Reset, then MULT a=0xFFFFFFFE (-2), b=3 -> busy high for exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA; start_pending=1 in the issue cycle only.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> after 5 busy cycles hi=0xFFFFFFFE, lo=0x00000001.
- DIV a=-7 (0xFFFFFFF9), b=2 -> busy 10 cycles; then lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). Also DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0. Also DIVU 100/7 -> lo=14, hi=2.
- With hi=0x11, lo=0x22, DIV by b=0 -> busy 10 cycles; hi=0x11, lo=0x22 unchanged; dz_err=1 until reset.
- MULT issued with flush=1 -> busy stays 0, hi/lo unchanged. Then MULT accepted, flush pulsed in cycle 2 of RUN -> completes normally with the correct result.
- MTHI a=0xDEAD -> hi=0xDEAD next cycle. MTLO issued while busy -> ignored, lo updated only by the running op's result. Reset asserted at busy cycle 3 -> hi=lo=0, busy=0 next cycle.
